// File: rtl/bk_arith_pkg.sv
// bk_arith_pkg: shared Brent-Kung arithmetic types and prefix-cell functions
//   BK_WIDTH : default operand width for the adder/subtractor family
//   gp_t     : generate/propagate pair carried through prefix nodes
//   black    : combines two (g,p) groups into one (g,p) group
//   grey     : resolves a group against an incoming carry, returning a carry
package bk_arith_pkg;
   localparam int BK_WIDTH = 32;
   typedef struct packed {
      logic g;
      logic p;
   } gp_t;
   function automatic gp_t black(input gp_t hi, input gp_t lo);
      gp_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction
   function automatic logic grey(input gp_t hi, input logic lo_g);
      return hi.g | (hi.p & lo_g);
   endfunction
endpackage

// File: rtl/bk_prefix_half.sv
// bk_prefix_half: Brent-Kung prefix over N bits with carry-in
//   g, p : per-bit generate/propagate (p is the half-sum bit)
//   cin  : carry into bit 0
//   sum  : p ^ carry for every bit
//   cout : carry out of bit N-1
module bk_prefix_half
   import bk_arith_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N-1:0] g,
   input  logic [N-1:0] p,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);
   // smallest power of two covering N; the down-sweep starts at half of it
   localparam int TOP = 1 << $clog2(N);
   gp_t        node [N];
   logic [N:0] c;
   always_comb begin
      for (int i = 0; i < N; i++) node[i] = '{g: g[i], p: p[i]};
      // up-sweep: node[i] becomes the group ending at i spanning 2*d bits
      for (int d = 1; d < N; d = d * 2)
         for (int i = 2 * d - 1; i < N; i += 2 * d) node[i] = black(node[i], node[i - d]);
      // down-sweep: fill the remaining positions from already-complete prefixes
      for (int d = TOP / 2; d >= 1; d = d / 2)
         for (int i = 3 * d - 1; i < N; i += 2 * d) node[i] = black(node[i], node[i - d]);
      c[0] = cin;
      for (int i = 0; i < N; i++) c[i + 1] = grey(node[i], cin);
   end
   assign sum  = p ^ c[N-1:0];
   assign cout = c[N];
endmodule

// File: rtl/bk_subtractor_pipe.sv
// bk_subtractor_pipe: 2-stage Brent-Kung subtractor (a - b) behind valid/ready
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake for a (minuend) and b (subtrahend)
//   out_valid/out_ready  : result handshake for diff, borrow (a < b), zero (diff == 0)
module bk_subtractor_pipe
   import bk_arith_pkg::*;
#(
   parameter int WIDTH = BK_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero
);
   localparam int HALF = WIDTH / 2;
   logic            v1, v2, rdy1, rdy2;
   logic [HALF-1:0] lo_sum, hi_sum;
   logic            lo_cout, hi_cout;
   logic [HALF-1:0] s1_lo, s1_g, s1_p;
   logic            s1_c;
   logic [WIDTH-1:0] nb, full;
   assign nb        = ~b;
   assign rdy2      = !v2 || out_ready;
   assign rdy1      = !v1 || rdy2;
   assign in_ready  = rdy1;
   assign out_valid = v2;
   // lower half resolved with cin=1 to form a + ~b + 1
   bk_prefix_half #(.N(HALF)) u_lo (
      .g   (a[HALF-1:0] & nb[HALF-1:0]),
      .p   (a[HALF-1:0] ^ nb[HALF-1:0]),
      .cin (1'b1),
      .sum (lo_sum),
      .cout(lo_cout)
   );
   // upper half seeded with the registered carry across the split
   bk_prefix_half #(.N(HALF)) u_hi (
      .g   (s1_g),
      .p   (s1_p),
      .cin (s1_c),
      .sum (hi_sum),
      .cout(hi_cout)
   );
   assign full = {hi_sum, s1_lo};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         s1_lo  <= '0;
         s1_g   <= '0;
         s1_p   <= '0;
         s1_c   <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
         zero   <= 1'b0;
      end else begin
         if (rdy2) v2 <= v1;
         if (rdy1) v1 <= in_valid;
         if (rdy1 && in_valid) begin
            s1_lo <= lo_sum;
            s1_c  <= lo_cout;
            s1_g  <= a[WIDTH-1:HALF] & nb[WIDTH-1:HALF];
            s1_p  <= a[WIDTH-1:HALF] ^ nb[WIDTH-1:HALF];
         end
         if (rdy2 && v1) begin
            diff   <= full;
            borrow <= ~hi_cout;
            zero   <= ~|full;
         end
      end
   end
endmodule
